// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulo counter and its prescaler.
//   CNT_UP / CNT_DOWN   : up_dn encodings
//   MODE_WRAP / MODE_SAT: SATURATE parameter values
//   clog2               : bit width needed to hold 0..n-1 (at least 1)
package counter_pkg;
  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  // Width of a counter holding 0..n-1; never returns 0 so the vector stays legal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles into count steps.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count enable; prescaler holds while low
//   sync_clr   : restarts the prescaler phase (clear or load in the top)
//   step       : high on the enabled cycle that completes PRESCALE enabled cycles
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic step
);
  generate
    if (PRESCALE == 1) begin : g_bypass
      // Every enabled cycle is a step; no state needed.
      assign step = en;
    end else begin : g_div
      localparam int PW = clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] psc_q, psc_d;

      assign step = en && (psc_q == LAST);

      always_comb begin
        psc_d = psc_q;
        if (sync_clr)  psc_d = '0;
        else if (step) psc_d = '0;
        else if (en)   psc_d = psc_q + PW'(1);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) psc_q <= '0;
        else        psc_q <= psc_d;
      end
    end
  endgenerate
endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load, clear, enable and prescaler.
//   clk, rst_n : clock, synchronous active-low reset
//   en, up_dn  : count enable and direction (1 = up)
//   clr        : clears count, prescaler and ovf
//   ld/ld_value: load (clamped to MAX_VAL), restarts prescaler
//   dout       : registered count, 0..MAX_VAL
//   tc         : one-cycle pulse on a step taken from the bound
//   ovf        : sticky bound-hit flag
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int          SATURATE = MODE_WRAP,
  parameter int          PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_value,
  output logic [WIDTH-1:0] dout,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_step;
  logic             tc_q, tc_d, ovf_q, ovf_d;
  logic             step, at_top, at_bot, bound;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_psc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clr | ld),
    .step     (step)
  );

  assign at_top = (cnt_q == MAX_V);
  assign at_bot = (cnt_q == '0);
  assign bound  = (up_dn == CNT_UP) ? at_top : at_bot;

  // Explicit bound compares: never relies on natural 2**WIDTH wrap.
  always_comb begin
    cnt_step = cnt_q;
    if (up_dn == CNT_UP) begin
      if (!at_top)                   cnt_step = cnt_q + WIDTH'(1);
      else if (SATURATE == MODE_SAT) cnt_step = MAX_V;
      else                           cnt_step = '0;
    end else begin
      if (!at_bot)                   cnt_step = cnt_q - WIDTH'(1);
      else if (SATURATE == MODE_SAT) cnt_step = '0;
      else                           cnt_step = MAX_V;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (ld) begin
      cnt_d = (ld_value > MAX_V) ? MAX_V : ld_value;
    end else if (step) begin
      cnt_d = cnt_step;
      tc_d  = bound;
      ovf_d = ovf_q | bound;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign dout = cnt_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench: three counters share one stimulus stream; each phase checks
// the instance whose parameters it exercises.
//   u_base: WIDTH=4 MAX_VAL=9 wrap, PRESCALE=1
//   u_sat : same, saturating
//   u_pre : same as base, PRESCALE=3
module tb_updown_mod_counter;
  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, clr, ld;
  logic [3:0] ld_value;
  logic [3:0] dout_b, dout_s, dout_p;
  logic       tc_b, tc_s, tc_p, ovf_b, ovf_s, ovf_p;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)) u_base (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .ld(ld),
    .ld_value(ld_value), .dout(dout_b), .tc(tc_b), .ovf(ovf_b));
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .ld(ld),
    .ld_value(ld_value), .dout(dout_s), .tc(tc_s), .ovf(ovf_s));
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)) u_pre (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .ld(ld),
    .ld_value(ld_value), .dout(dout_p), .tc(tc_p), .ovf(ovf_p));

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. reset overrides load and enable
    rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; clr = 1'b0; ld = 1'b1; ld_value = 4'd5;
    tick(); tick();
    chk("rst_dout", dout_b, 0); chk("rst_tc", tc_b, 0); chk("rst_ovf", ovf_b, 0);
    chk("rst_dout_sat", dout_s, 0); chk("rst_dout_pre", dout_p, 0);
    rst_n = 1'b1; en = 1'b0; ld = 1'b0;
    tick(); chk("hold0", dout_b, 0);

    // 2. up wrap
    ld = 1'b1; ld_value = 4'd7; tick(); chk("ld7", dout_b, 7);
    ld = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick(); chk("up8", dout_b, 8); chk("up8_tc", tc_b, 0); chk("up8_ovf", ovf_b, 0);
    tick(); chk("up9", dout_b, 9); chk("up9_tc", tc_b, 0);
    tick(); chk("wrap0", dout_b, 0); chk("wrap0_tc", tc_b, 1); chk("wrap0_ovf", ovf_b, 1);
    en = 1'b0; tick(); chk("idle_tc", tc_b, 0); chk("ovf_sticky", ovf_b, 1);
    chk("idle_hold", dout_b, 0);

    // 3. down wrap, then clear
    en = 1'b1; up_dn = 1'b0;
    tick(); chk("dn9", dout_b, 9); chk("dn9_tc", tc_b, 1);
    tick(); chk("dn8", dout_b, 8); chk("dn8_tc", tc_b, 0); chk("dn8_ovf", ovf_b, 1);
    en = 1'b0; clr = 1'b1;
    tick(); chk("clr_dout", dout_b, 0); chk("clr_ovf", ovf_b, 0); chk("clr_tc", tc_b, 0);
    clr = 1'b0;

    // 4. saturation
    ld = 1'b1; ld_value = 4'd8; tick(); chk("sat_ld8", dout_s, 8);
    ld = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick(); chk("sat_s1", dout_s, 9); chk("sat_s1_tc", tc_s, 0);
    tick(); chk("sat_s2", dout_s, 9); chk("sat_s2_tc", tc_s, 1); chk("sat_s2_ovf", ovf_s, 1);
    tick(); chk("sat_s3", dout_s, 9); chk("sat_s3_tc", tc_s, 1);
    en = 1'b0; clr = 1'b1; tick(); chk("sat_clr", dout_s, 0); chk("sat_clr_ovf", ovf_s, 0);
    clr = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick(); chk("sat_dn0", dout_s, 0); chk("sat_dn0_tc", tc_s, 1); chk("wrap_dn9", dout_b, 9);
    en = 1'b0; tick(); chk("sat_tc_drop", tc_s, 0);

    // 5. clamp and priority
    ld = 1'b1; ld_value = 4'd12; tick(); chk("clamp", dout_b, 9);
    en = 1'b1; up_dn = 1'b1; ld_value = 4'd3; tick(); chk("ld_over_en", dout_b, 3);
    chk("ld_tc", tc_b, 0);
    clr = 1'b1; tick(); chk("clr_over_ld", dout_b, 0);
    clr = 1'b0; en = 1'b0; ld_value = 4'd5; tick(); chk("ld5", dout_b, 5);
    ld = 1'b0; en = 1'b1; tick(); chk("cnt6", dout_b, 6);
    rst_n = 1'b0; tick(); chk("rst_mid", dout_b, 0); chk("rst_mid_ovf", ovf_b, 0);
    rst_n = 1'b1; en = 1'b0;

    // 6. prescaler: steps on enabled cycles 3, 6, 9
    clr = 1'b1; tick(); clr = 1'b0; chk("pre_clr", dout_p, 0);
    en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("pre_c%0d", i), dout_p, i / 3);
    end
    en = 1'b0; tick(); chk("pre_hold", dout_p, 3);
    // phase held at 0 across en=0; one enabled cycle then load restarts it
    en = 1'b1; tick(); chk("pre_c1b", dout_p, 3);
    ld = 1'b1; ld_value = 4'd4; tick(); chk("pre_ld", dout_p, 4);
    ld = 1'b0;
    tick(); chk("pre_after1", dout_p, 4);
    tick(); chk("pre_after2", dout_p, 4);
    tick(); chk("pre_after3", dout_p, 5);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got stalled expected completion");
    $fatal(1);
  end
endmodule
